bsg_link_upstream_serializer: RTL and testbench
===============================================

// Module: bsg_link_upstream_serializer
// PURPOSE
//  Upstream (core->link) output stage of the BSG link. Accepts one CORE_W-bit word per
//  valid/ready handshake, slices it into BEATS beats over CH_NUM parallel channels of
//  CH_W bits each, and drives them to the I/O pads. Sends are credit-gated: tokens from
//  the downstream receiver return credits. Generalises the fixed 64b/2ch/8b/64-credit sender
//  to arbitrary widths, channel count and credit depth. Adds back-to-back packet streaming.
// PARAMETERS
//  CORE_W        64  core word width; must be a multiple of CH_NUM*CH_W
//  CH_NUM         2  number of physical output channels
//  CH_W           8  bits per channel per beat
//  CREDITS       64  max packets in flight; power of two, >=2
//  TOKEN_DECIM    1  credits returned per io_token_i pulse; power of two, <=CREDITS
//  derived: BEATS=CORE_W/(CH_NUM*CH_W); CNT_W=$clog2(CREDITS)+1
// PORTS
//  clk           in   1                clock
//  rst           in   1                reset, synchronous, active-high
//  core_data_i   in   CORE_W           word to send
//  core_valid_i  in   1                core_data_i valid
//  core_ready_o  out  1                block accepts core_data_i this cycle
//  io_token_i    in   1                one-cycle credit-return pulse (already synchronised to clk)
//  io_valid_o    out  1                io_data_o carries a beat
//  io_data_o     out  CH_NUM*CH_W      channel c = io_data_o[c*CH_W +: CH_W]
//  credits_o     out  CNT_W            packets currently in flight (sent - finished)
//  credit_err_o  out  1                sticky: token received while credits_o < TOKEN_DECIM
// BEHAVIOUR
//  Reset: all regs cleared; io_valid_o=0, io_data_o=0, credits_o=0, credit_err_o=0,
//   state=IDLE, beat=0. core_ready_o=0 while rst is high. A reset mid-packet aborts
//   the packet immediately: no further beats are sent and in-flight credits are dropped.
//  Credit counter: sent_cnt and finish_cnt are CNT_W-bit wrapping counters.
//   credits_o = sent_cnt - finish_cnt (mod 2^CNT_W). can_send = credits_o < CREDITS.
//  sent_cnt += 1 on accept (one credit per packet, not per beat).
//  finish_cnt += TOKEN_DECIM on io_token_i when credits_o >= TOKEN_DECIM. Otherwise the
//   token is ignored and credit_err_o is set, staying high until rst.
//  A simultaneous accept and token apply both updates in the same cycle.
//  FSM: IDLE, SEND.
//   core_ready_o = can_send & (state==IDLE | (state==SEND & beat==BEATS-1)).
//   accept = core_valid_i & core_ready_o. On accept, core_data_i is latched into buf.
//   IDLE --accept--> SEND, beat=0.
//   SEND: each cycle drive beat `beat`, then beat++.
//   At beat==BEATS-1: on accept, go to beat 0 of the new word (no bubble);
//   without accept, go to IDLE.
//  Latency: accept at cycle N -> beat 0 registered on io_* at N+1, last beat at N+BEATS.
//   Continuous valid with credits available gives 100% pad utilisation.
//  Beat mapping: beat k, channel c = buf[(k*CH_NUM+c)*CH_W +: CH_W] (LSB slice first).
//  io_data_o holds its last value when io_valid_o=0 (no toggling on idle pads).
//  Credit exhaustion: core_ready_o drops. The packet in progress still completes all its
//   beats; credits only gate packet starts.
//  BEATS==1: SEND lasts one cycle per word; the back-to-back rule still applies.
// STRUCTURE
//  Package bsg_link_pkg: state_e {IDLE,SEND}; localparams BEATS, CNT_W; function
//   beat_slice(buf,k) returning CH_NUM*CH_W bits.
//  Sub-module bsg_link_credit_counter #(CREDITS,TOKEN_DECIM): inc_i, token_i ->
//   credits_o, can_send_o, err_o. Top holds the FSM, beat counter, buf and output regs.
// TESTING (defaults unless noted)
//  1 Single word 64'h0807_0605_0403_0201, token held low -> io_valid_o high 4 cycles;
//    io_data_o = 16'h0201, 0403, 0605, 0807; credits_o=1; then io_valid_o=0.
//  2 Eight words with valid held high -> 32 consecutive valid beats with no bubble;
//    core_ready_o is high only in IDLE or at beat 3.
//  3 Send 64 packets, no tokens -> credits_o=64 and core_ready_o=0. One token ->
//    credits_o=63, ready returns the next cycle, and the 65th packet is sent.
//  4 Accept coinciding with a token at credits_o=10 -> credits_o stays 10.
//    A token at credits_o=0 -> credit_err_o=1 and credits_o stays 0.
//  5 rst asserted at beat 2 -> next cycle io_valid_o=0, credits_o=0, state IDLE;
//    the following word starts cleanly at beat 0.
//  6 CORE_W=32, CH_NUM=4, CH_W=8, CREDITS=4, TOKEN_DECIM=2 -> BEATS=1. Four packets fill
//    the credits; one token -> credits_o=2.

Source files
------------

// File: rtl/bsg_link_pkg.sv
// Shared types and sizing helpers for the BSG link upstream serializer.
// FSM state encoding plus width/offset arithmetic used by the serializer and credit counter.
package bsg_link_pkg;

    typedef logic [0:0] state_e;

    localparam state_e IDLE = 1'b0;
    localparam state_e SEND = 1'b1;

    function automatic int calc_beats(input int core_w, input int ch_num, input int ch_w);
        return core_w / (ch_num * ch_w);
    endfunction

    function automatic int calc_cnt_w(input int credits);
        return $clog2(credits) + 1;
    endfunction

    // Bit offset of beat k in the latched word; beats are taken LSB slice first.
    function automatic int beat_offset(input int k, input int lane_w);
        return k * lane_w;
    endfunction

endpackage

// File: rtl/bsg_link_credit_counter.sv
// Packets-in-flight tracker: wrapping sent/finished counters whose difference is the
// outstanding credit count, with a sticky flag for tokens that would underflow it.
module bsg_link_credit_counter
    import bsg_link_pkg::*;
#(
    parameter int CREDITS     = 64,
    parameter int TOKEN_DECIM = 1,
    localparam int CNT_W      = calc_cnt_w(CREDITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             token,
    output logic [CNT_W-1:0] credits,
    output logic             can_send,
    output logic             err
);

    logic [CNT_W-1:0] sent_cnt;
    logic [CNT_W-1:0] finish_cnt;
    logic             token_ok;

    // One extra counter bit lets a full window (CREDITS outstanding) differ from empty.
    assign credits  = sent_cnt - finish_cnt;
    assign can_send = credits < CNT_W'(CREDITS);
    assign token_ok = credits >= CNT_W'(TOKEN_DECIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            sent_cnt   <= '0;
            finish_cnt <= '0;
            err        <= 1'b0;
        end else begin
            if (inc) begin
                sent_cnt <= sent_cnt + CNT_W'(1);
            end
            if (token) begin
                if (token_ok) begin
                    finish_cnt <= finish_cnt + CNT_W'(TOKEN_DECIM);
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bsg_link_upstream_serializer.sv
// Core-to-link output stage: latches one core word per handshake and streams it out as
// BEATS beats over CH_NUM pad channels, gated by downstream credits.
module bsg_link_upstream_serializer
    import bsg_link_pkg::*;
#(
    parameter int CORE_W      = 64,
    parameter int CH_NUM      = 2,
    parameter int CH_W        = 8,
    parameter int CREDITS     = 64,
    parameter int TOKEN_DECIM = 1,
    localparam int CNT_W      = calc_cnt_w(CREDITS),
    localparam int LANE_W     = CH_NUM * CH_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CORE_W-1:0] core_data_i,
    input  logic              core_valid_i,
    output logic              core_ready_o,
    input  logic              io_token_i,
    output logic              io_valid_o,
    output logic [LANE_W-1:0] io_data_o,
    output logic [CNT_W-1:0]  credits_o,
    output logic              credit_err_o
);

    localparam int BEATS  = calc_beats(CORE_W, CH_NUM, CH_W);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    function automatic logic [LANE_W-1:0] beat_slice(input logic [CORE_W-1:0] word, input int k);
        return word[beat_offset(k, LANE_W) +: LANE_W];
    endfunction

    logic [CORE_W-1:0] word_q;
    state_e            state;
    logic [BEAT_W-1:0] beat;
    logic              can_send;
    logic              accept;
    logic              last_beat;

    bsg_link_credit_counter #(
        .CREDITS     (CREDITS),
        .TOKEN_DECIM (TOKEN_DECIM)
    ) credit_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (accept),
        .token    (io_token_i),
        .credits  (credits_o),
        .can_send (can_send),
        .err      (credit_err_o)
    );

    // beat indexes the slice currently on the pads, so accepting during the last beat
    // puts the next word's beat 0 out on the following cycle with no bubble.
    assign last_beat    = (beat == LAST_BEAT);
    assign core_ready_o = !rst && can_send && (state == IDLE || (state == SEND && last_beat));
    assign accept       = core_valid_i && core_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q     <= '0;
            state      <= IDLE;
            beat       <= '0;
            io_valid_o <= 1'b0;
            io_data_o  <= '0;
        end else if (accept) begin
            word_q     <= core_data_i;
            io_data_o  <= beat_slice(core_data_i, 0);
            io_valid_o <= 1'b1;
            state      <= SEND;
            beat       <= '0;
        end else if (state == SEND && !last_beat) begin
            io_data_o  <= beat_slice(word_q, int'(beat) + 1);
            io_valid_o <= 1'b1;
            beat       <= beat + BEAT_W'(1);
        end else begin
            // Pads keep their last data while idle.
            state      <= IDLE;
            beat       <= '0;
            io_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bsg_link_upstream_serializer.sv
// Directed bench for the upstream serializer: default 64b/2ch/8b configuration plus a
// single-beat 32b/4ch configuration with decimated tokens.
module tb_bsg_link_upstream_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] data;
    logic        valid;
    logic        ready;
    logic        token;
    logic        io_valid;
    logic [15:0] io_data;
    logic [6:0]  credits;
    logic        err;

    logic [31:0] data6;
    logic        valid6;
    logic        ready6;
    logic        token6;
    logic        io_valid6;
    logic [31:0] io_data6;
    logic [2:0]  credits6;
    logic        err6;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bsg_link_upstream_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .core_data_i  (data),
        .core_valid_i (valid),
        .core_ready_o (ready),
        .io_token_i   (token),
        .io_valid_o   (io_valid),
        .io_data_o    (io_data),
        .credits_o    (credits),
        .credit_err_o (err)
    );

    bsg_link_upstream_serializer #(
        .CORE_W      (32),
        .CH_NUM      (4),
        .CH_W        (8),
        .CREDITS     (4),
        .TOKEN_DECIM (2)
    ) dut6 (
        .clk          (clk),
        .rst          (rst),
        .core_data_i  (data6),
        .core_valid_i (valid6),
        .core_ready_o (ready6),
        .io_token_i   (token6),
        .io_valid_o   (io_valid6),
        .io_data_o    (io_data6),
        .credits_o    (credits6),
        .credit_err_o (err6)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] make_word(input int i);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) w[b*8 +: 8] = {4'(i), 4'(b)};
        return w;
    endfunction

    logic [15:0] t1_exp [4];

    initial begin
        t1_exp[0] = 16'h0201; t1_exp[1] = 16'h0403; t1_exp[2] = 16'h0605; t1_exp[3] = 16'h0807;
        rst = 1'b1; valid = 1'b0; token = 1'b0; data = '0;
        valid6 = 1'b0; token6 = 1'b0; data6 = '0;
        step(); step();

        // Reset state
        valid = 1'b1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_io_valid", 64'(io_valid), 64'd0);
        chk("rst_io_data", 64'(io_data), 64'd0);
        chk("rst_credits", 64'(credits), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        valid = 1'b0;
        rst = 1'b0;
        step();

        // 1: single word
        data = 64'h0807_0605_0403_0201; valid = 1'b1;
        chk("t1_ready_idle", 64'(ready), 64'd1);
        step();
        valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t1_io_valid", 64'(io_valid), 64'd1);
            chk("t1_io_data", 64'(io_data), 64'(t1_exp[k]));
            chk("t1_credits", 64'(credits), 64'd1);
            step();
        end
        chk("t1_idle_valid", 64'(io_valid), 64'd0);
        chk("t1_idle_hold", 64'(io_data), 64'h0807);

        // 2: eight back-to-back words
        valid = 1'b1;
        for (int t = 0; t < 32; t++) begin
            data = make_word(t / 4);
            chk("t2_ready", 64'(ready), 64'((t % 4) == 0));
            step();
            chk("t2_io_valid", 64'(io_valid), 64'd1);
            chk("t2_io_data", 64'(io_data),
                64'({4'(t / 4), 4'(2 * (t % 4) + 1), 4'(t / 4), 4'(2 * (t % 4))}));
        end
        valid = 1'b0;
        step();
        chk("t2_end_valid", 64'(io_valid), 64'd0);
        chk("t2_credits", 64'(credits), 64'd9);

        // 3: exhaust credits, then one token
        valid = 1'b1; data = 64'h5555_5555_5555_5555;
        for (int n = 0; n < 400 && credits != 7'd64; n++) step();
        chk("t3_credits_full", 64'(credits), 64'd64);
        chk("t3_ready_low", 64'(ready), 64'd0);
        step(); step(); step();
        chk("t3_last_beat_valid", 64'(io_valid), 64'd1);
        chk("t3_ready_last_beat", 64'(ready), 64'd0);
        step();
        chk("t3_stalled", 64'(io_valid), 64'd0);
        valid = 1'b0; token = 1'b1;
        step();
        token = 1'b0;
        chk("t3_credits_63", 64'(credits), 64'd63);
        chk("t3_ready_back", 64'(ready), 64'd1);
        data = 64'h0000_0000_0000_CAFE; valid = 1'b1;
        step();
        valid = 1'b0;
        chk("t3_pkt65_valid", 64'(io_valid), 64'd1);
        chk("t3_pkt65_data", 64'(io_data), 64'hCAFE);
        chk("t3_pkt65_credits", 64'(credits), 64'd64);
        step(); step(); step(); step();

        // 4: simultaneous accept+token, then underflow
        token = 1'b1;
        for (int n = 0; n < 54; n++) step();
        token = 1'b0;
        chk("t4_credits_10", 64'(credits), 64'd10);
        valid = 1'b1; token = 1'b1; data = 64'h1;
        chk("t4_ready", 64'(ready), 64'd1);
        step();
        valid = 1'b0; token = 1'b0;
        chk("t4_credits_same", 64'(credits), 64'd10);
        step(); step(); step(); step();
        token = 1'b1;
        for (int n = 0; n < 10; n++) step();
        chk("t4_credits_0", 64'(credits), 64'd0);
        chk("t4_no_err_yet", 64'(err), 64'd0);
        step();
        token = 1'b0;
        chk("t4_err_set", 64'(err), 64'd1);
        chk("t4_credits_stay0", 64'(credits), 64'd0);
        step();
        chk("t4_err_sticky", 64'(err), 64'd1);

        // 5: reset mid-packet
        data = 64'h1716_1514_1312_1110; valid = 1'b1;
        step();
        valid = 1'b0;
        step(); step();
        chk("t5_beat2", 64'(io_data), 64'h1514);
        rst = 1'b1;
        step();
        chk("t5_rst_valid", 64'(io_valid), 64'd0);
        chk("t5_rst_credits", 64'(credits), 64'd0);
        chk("t5_rst_err", 64'(err), 64'd0);
        chk("t5_rst_ready", 64'(ready), 64'd0);
        rst = 1'b0;
        step();
        chk("t5_still_idle", 64'(io_valid), 64'd0);
        data = 64'h2726_2524_2322_2120; valid = 1'b1;
        chk("t5_ready_after", 64'(ready), 64'd1);
        step();
        valid = 1'b0;
        chk("t5_restart_valid", 64'(io_valid), 64'd1);
        chk("t5_restart_data", 64'(io_data), 64'h2120);
        chk("t5_restart_credits", 64'(credits), 64'd1);
        step();
        chk("t5_restart_beat1", 64'(io_data), 64'h2322);
        step(); step(); step();

        // 6: single-beat configuration with decimated tokens
        valid6 = 1'b1;
        for (int p = 0; p < 4; p++) begin
            data6 = 32'hA0B0_C0D0 + 32'(p);
            chk("t6_ready", 64'(ready6), 64'd1);
            step();
            chk("t6_io_valid", 64'(io_valid6), 64'd1);
            chk("t6_io_data", 64'(io_data6), 64'(32'hA0B0_C0D0 + 32'(p)));
        end
        chk("t6_full_ready", 64'(ready6), 64'd0);
        chk("t6_full_credits", 64'(credits6), 64'd4);
        valid6 = 1'b0;
        step();
        chk("t6_idle", 64'(io_valid6), 64'd0);
        token6 = 1'b1;
        step();
        token6 = 1'b0;
        chk("t6_credits_2", 64'(credits6), 64'd2);
        chk("t6_ready_back", 64'(ready6), 64'd1);
        token6 = 1'b1;
        step();
        chk("t6_credits_0", 64'(credits6), 64'd0);
        chk("t6_no_err", 64'(err6), 64'd0);
        step();
        token6 = 1'b0;
        chk("t6_err", 64'(err6), 64'd1);
        chk("t6_credits_stay0", 64'(credits6), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
